uart_baud_gen: RTL

Programmable baud-tick generator for the UART datapath. It replaces the fixed 4-bit modulus timer with a wide runtime-loadable divisor and an optional fractional-divisor accumulator. It adds glitch-free divisor updates, a synchronous phase clear for RX start-bit alignment, and a derived bit-rate tick. It feeds `tick_os` to the RX/TX oversampling FSMs and `tick_bit` to the TX shifter.

---
 rtl/uart_baud_pkg.sv | 16 +
 rtl/uart_baud_gen_if.sv | 31 +++
 rtl/uart_frac_acc.sv | 34 +++
 rtl/uart_baud_gen.sv | 93 +++++++++
 4 files changed

// File: rtl/uart_baud_pkg.sv
// Shared defaults and types for the UART baud-tick generator.
// Fractional divisor support is selected by the UART_BAUD_FRAC_EN macro.
package uart_baud_pkg;

   localparam int unsigned UART_CNT_W   = 16;
   localparam int unsigned UART_FRAC_W  = 4;
   localparam int unsigned UART_OSR     = 16;
   localparam int unsigned UART_DIV_RST = 650;
   localparam int unsigned UART_OS_W    = $clog2(UART_OSR);

   typedef struct packed {
      logic [UART_CNT_W-1:0]  div_int;
      logic [UART_FRAC_W-1:0] div_frac;
   } uart_div_t;

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control and tick bundle between the UART datapath and the baud generator.
interface uart_baud_gen_if
   import uart_baud_pkg::*;
#(
   parameter int unsigned CNT_W  = UART_CNT_W,
   parameter int unsigned FRAC_W = UART_FRAC_W,
   parameter int unsigned OSR    = UART_OSR
);
   localparam int unsigned OS_W = $clog2(OSR);

   logic              enable;
   logic              clr;
   logic              div_wr;
   logic [CNT_W-1:0]  div_int;
   logic [FRAC_W-1:0] div_frac;
   logic              div_pending;
   logic              tick_os;
   logic              tick_bit;
   logic [OS_W-1:0]   os_cnt;

   modport master (
      output enable, clr, div_wr, div_int, div_frac,
      input  div_pending, tick_os, tick_bit, os_cnt
   );

   modport slave (
      input  enable, clr, div_wr, div_int, div_frac,
      output div_pending, tick_os, tick_bit, os_cnt
   );

endinterface

// File: rtl/uart_frac_acc.sv
// Fractional-divisor phase accumulator; only built when UART_BAUD_FRAC_EN is defined.
`ifdef UART_BAUD_FRAC_EN
module uart_frac_acc
   import uart_baud_pkg::*;
#(
   parameter int unsigned FRAC_W = UART_FRAC_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [FRAC_W-1:0] frac,
   input  logic              advance,
   input  logic              zero,
   output logic              carry
);

   logic [FRAC_W-1:0] acc_q;
   logic [FRAC_W:0]   sum;

   // Carry stretches the current period by one cycle.
   assign sum   = {1'b0, acc_q} + {1'b0, frac};
   assign carry = sum[FRAC_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
      end else if (zero) begin
         acc_q <= '0;
      end else if (advance) begin
         acc_q <= sum[FRAC_W-1:0];
      end
   end

endmodule
`endif

// File: rtl/uart_baud_gen.sv
// Programmable oversample/bit tick generator with shadowed divisor updates.
// Define UART_BAUD_FRAC_EN to add the fractional-divisor accumulator.
module uart_baud_gen
   import uart_baud_pkg::*;
#(
   parameter int unsigned CNT_W   = UART_CNT_W,
   parameter int unsigned FRAC_W  = UART_FRAC_W,
   parameter int unsigned OSR     = UART_OSR,
   parameter int unsigned DIV_RST = UART_DIV_RST
) (
   input logic            clk,
   input logic            reset_n,
   uart_baud_gen_if.slave bus
);

   localparam int unsigned OS_W = $clog2(OSR);

   logic [CNT_W:0]   cnt_q;
   logic [CNT_W:0]   limit;
   logic [CNT_W-1:0] div_a_q;
   logic [CNT_W-1:0] div_s_q;
   logic [OS_W-1:0]  os_q;
   logic             pend_q;
   logic             tick;
   logic             apply;
   logic             carry;

`ifdef UART_BAUD_FRAC_EN
   logic [FRAC_W-1:0] frac_a_q;
   logic [FRAC_W-1:0] frac_s_q;

   uart_frac_acc #(
      .FRAC_W (FRAC_W)
   ) u_frac_acc (
      .clk     (clk),
      .reset_n (reset_n),
      .frac    (frac_a_q),
      .advance (tick),
      .zero    (bus.clr | apply),
      .carry   (carry)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frac_a_q <= '0;
         frac_s_q <= '0;
      end else begin
         if (apply) frac_a_q <= frac_s_q;
         if (bus.div_wr) frac_s_q <= bus.div_frac;
      end
   end
`else
   logic [FRAC_W-1:0] unused_div_frac;

   assign unused_div_frac = bus.div_frac;
   assign carry           = 1'b0;
`endif

   // One extra bit keeps limit from wrapping when div_a_q is all ones.
   assign limit = {1'b0, div_a_q} + {{CNT_W{1'b0}}, carry};
   assign tick  = bus.enable & ~bus.clr & (cnt_q == limit);
   assign apply = pend_q & (tick | ~bus.enable | bus.clr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         os_q    <= '0;
         div_a_q <= CNT_W'(DIV_RST);
         div_s_q <= CNT_W'(DIV_RST);
         pend_q  <= 1'b0;
      end else begin
         if (bus.clr) begin
            cnt_q <= '0;
            os_q  <= '0;
         end else if (tick) begin
            cnt_q <= '0;
            os_q  <= os_q + 1'b1;
         end else if (bus.enable) begin
            cnt_q <= cnt_q + 1'b1;
         end
         // Apply samples the old shadow; a coincident write re-arms pending.
         if (apply) div_a_q <= div_s_q;
         if (bus.div_wr) div_s_q <= bus.div_int;
         pend_q <= bus.div_wr | (pend_q & ~apply);
      end
   end

   assign bus.tick_os     = tick;
   assign bus.tick_bit    = tick & (os_q == OS_W'(OSR - 1));
   assign bus.os_cnt      = os_q;
   assign bus.div_pending = pend_q;

endmodule
